// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell adds two WIDTH-bit
// operands one bit per clock, LSB first, with a start/busy/done handshake.

// Single-bit full adder cell, time-shared by the sequencer below.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             load, last;

  // The single shared adder cell always looks at the operand LSBs.
  fulladder u_fa (op_a[0], op_b[0], carry_q, fa_sum, fa_carry);

  // A new request is only taken when not processing bits; DONE accepts too so
  // back-to-back additions lose no cycle.
  assign load = start && (state == IDLE || state == DONE);
  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state logic.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = RUN;
      RUN:     if (last)  next = DONE;
      DONE:    next = start ? RUN : IDLE;
      default: next = IDLE;
    endcase
  end

  // Operand shifting, carry/count bookkeeping and result capture; sum/cout
  // only move on the edge that enters DONE so they hold between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      op_a    <= a;
      op_b    <= b;
      carry_q <= cin;
      cnt     <= '0;
      acc     <= '0;
    end else if (state == RUN) begin
      acc     <= {fa_sum, acc[WIDTH-1:1]};
      op_a    <= op_a >> 1;
      op_b    <= op_b >> 1;
      carry_q <= fa_carry;
      cnt     <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_sum, acc[WIDTH-1:1]};
        cout <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver pushes hand-computed
// results as each request is accepted; a negedge monitor pops on every done.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout;
  logic [15:0] sum;

  typedef struct {
    logic [16:0] res;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;

  serial_add_ctrl #(.WIDTH(16), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum",  {16'd0, sum}, {16'd0, e.res[15:0]});
        check("cout", {31'd0, cout}, {31'd0, e.res[16]});
        check("latency", cyc - e.acc_cyc, 32'd16);
      end
    end
  end

  // Present a request for one cycle and record its expected result.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input logic [16:0] exp);
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; cin = ic;
    @(posedge clk); #1;
    e.res = exp; e.acc_cyc = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 32'd1, 32'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    t = -1;
    while (n < 40) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) check("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, t1, t2;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;

    // Carry ripple across every bit, with busy-length check.
    issue(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
    nb = 1;  // busy seen at the negedge inside issue()
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("busy_cycles", nb, 32'd16);
    wait_drain();

    issue(16'h1234, 16'h4321, 1'b1, 17'h0_5556);
    wait_drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
    wait_drain();

    // Operand change and start pulse during RUN must be ignored.
    issue(16'h00FF, 16'h0F0F, 1'b0, 17'h0_100E);
    repeat (4) @(negedge clk);
    a = 16'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    check("hold_sum", {16'd0, sum}, 32'h100E);

    // Reset mid-run aborts without a done pulse.
    issue(16'h8000, 16'h8000, 1'b0, 17'h1_0000);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum",  {16'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    repeat (20) @(negedge clk);
    issue(16'h0003, 16'h0004, 1'b0, 17'h0_0007);
    wait_drain();

    // Back-to-back: start held high, new operands during DONE.
    begin
      exp_t e;
      @(negedge clk);
      start = 1'b1; a = 16'd1; b = 16'd1; cin = 1'b0;
      @(posedge clk); #1;
      e.res = 17'h0_0002; e.acc_cyc = cyc;
      q.push_back(e);
      wait_done(t1);
      a = 16'd2; b = 16'd2;
      @(posedge clk); #1;
      e.res = 17'h0_0004; e.acc_cyc = cyc;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_done(t2);
      check("b2b_spacing", t2 - t1, 32'd17);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
